// File: rtl/modbus_resp_tx_pkg.sv
// Shared Modbus RTU constants, FSM encoding and frame-kind type for the slave reply path.
// Pure declarations: no latency, no flow control.
package modbus_resp_tx_pkg;

  localparam logic [7:0]  MB_FC_READ_HOLD    = 8'h03;
  localparam logic [7:0]  MB_FC_READ_INPUT   = 8'h04;
  localparam logic [7:0]  MB_FC_WRITE_SINGLE = 8'h06;
  localparam logic [7:0]  MB_EXC_FLAG        = 8'h80;
  localparam logic [15:0] CRC_INIT           = 16'hFFFF;
  localparam logic [15:0] CRC_POLY           = 16'hA001;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
  localparam logic [2:0] ST_WAIT_TX  = 3'd5;
  localparam logic [2:0] ST_CRC_WAIT = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [1:0] {
    FRM_EXC   = 2'd0,
    FRM_READ  = 2'd1,
    FRM_WRITE = 2'd2,
    FRM_NONE  = 2'd3
  } frame_kind_t;

endpackage

// File: rtl/mb_crc16_serial.sv
// Bit-serial CRC-16/MODBUS: one bit per cycle, 8 cycles per byte after byte_valid.
// Bytes are accepted only while crc_ready is high; init restarts from CRC_INIT.
module mb_crc16_serial
  import modbus_resp_tx_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        init,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc,
  output logic        crc_ready
);

  logic [7:0] shift;
  logic [3:0] bit_cnt;

  assign crc_ready = (bit_cnt == 4'd0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc     <= CRC_INIT;
      shift   <= 8'h00;
      bit_cnt <= 4'd0;
    end else if (init) begin
      crc     <= CRC_INIT;
      bit_cnt <= 4'd0;
    end else if (byte_valid && crc_ready) begin
      shift   <= byte_in;
      bit_cnt <= 4'd8;
    end else if (!crc_ready) begin
      // reflected form: LSB of data and CRC are combined first
      crc     <= {1'b0, crc[15:1]} ^ ((crc[0] ^ shift[0]) ? CRC_POLY : 16'h0000);
      shift   <= {1'b0, shift[7:1]};
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/modbus_resp_tx.sv
// Modbus RTU reply builder: exception / register-read / write-echo frames plus CRC, streamed to the UART.
// First tx_start 2 cycles after exception_done; each byte waits for the tx_busy rise and fall.
module modbus_resp_tx
  import modbus_resp_tx_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         MAX_REGS   = 5
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        exception_done,
  input  logic [7:0]  exception,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic [15:0] reg_rd_addr,
  input  logic [15:0] reg_rd_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_busy,
  output logic        frame_done
);

  localparam logic [7:0] MAX_N = 8'(MAX_REGS);

  logic [2:0]  state;
  frame_kind_t kind;
  logic [7:0]  func_q;
  logic [7:0]  exc_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [3:0]  len_q;
  logic [3:0]  byte_cnt;
  logic [2:0]  reg_idx;
  logic [15:0] hold;
  logic        crc_phase;
  logic        crc_idx;

  frame_kind_t req_kind;
  logic [2:0]  req_n;
  logic [3:0]  req_len;
  logic [3:0]  nxt_cnt;
  logic        data_hi;
  logic [7:0]  payload_byte;
  logic [7:0]  next_byte;
  logic        crc_init;
  logic        crc_feed;
  logic [15:0] crc;
  logic        crc_ready;

  assign tx_start   = (state == ST_START);
  assign frame_done = (state == ST_DONE);
  assign frame_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign crc_init   = (state == ST_IDLE) && exception_done;
  assign crc_feed   = (state == ST_START) && !crc_phase;
  assign nxt_cnt    = byte_cnt + 4'd1;
  // data bytes start at index 3, so odd indices are the high byte of a fresh register
  assign data_hi    = (kind == FRM_READ) && byte_cnt[0] && (byte_cnt >= 4'd3);
  assign req_n      = (data[7:0] > MAX_N) ? MAX_N[2:0] : data[2:0];

  always_comb begin
    req_kind = FRM_NONE;
    if (exception != 8'h00) begin
      req_kind = FRM_EXC;
    end else if (func_code == MB_FC_READ_HOLD || func_code == MB_FC_READ_INPUT) begin
      req_kind = FRM_READ;
    end else if (func_code == MB_FC_WRITE_SINGLE) begin
      req_kind = FRM_WRITE;
    end
  end

  always_comb begin
    case (req_kind)
      FRM_EXC:   req_len = 4'd3;
      FRM_READ:  req_len = 4'd3 + {req_n, 1'b0};
      FRM_WRITE: req_len = 4'd6;
      default:   req_len = 4'd0;
    endcase
  end

  always_comb begin
    payload_byte = 8'h00;
    case (kind)
      FRM_EXC: begin
        case (byte_cnt)
          4'd0:    payload_byte = SLAVE_ADDR;
          4'd1:    payload_byte = func_q | MB_EXC_FLAG;
          default: payload_byte = exc_q;
        endcase
      end
      FRM_READ: begin
        case (byte_cnt)
          4'd0:    payload_byte = SLAVE_ADDR;
          4'd1:    payload_byte = func_q;
          4'd2:    payload_byte = {4'h0, len_q - 4'd3};
          default: payload_byte = data_hi ? reg_rd_data[15:8] : hold[7:0];
        endcase
      end
      FRM_WRITE: begin
        case (byte_cnt)
          4'd0:    payload_byte = SLAVE_ADDR;
          4'd1:    payload_byte = func_q;
          4'd2:    payload_byte = addr_q[15:8];
          4'd3:    payload_byte = addr_q[7:0];
          4'd4:    payload_byte = data_q[15:8];
          default: payload_byte = data_q[7:0];
        endcase
      end
      default: payload_byte = 8'h00;
    endcase
  end

  assign next_byte = crc_phase ? (crc_idx ? crc[15:8] : crc[7:0]) : payload_byte;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      kind        <= FRM_NONE;
      func_q      <= 8'h00;
      exc_q       <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      len_q       <= 4'd0;
      byte_cnt    <= 4'd0;
      reg_idx     <= 3'd0;
      hold        <= 16'h0000;
      crc_phase   <= 1'b0;
      crc_idx     <= 1'b0;
      tx_data     <= 8'h00;
      reg_rd_addr <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exception_done) begin
            kind      <= req_kind;
            func_q    <= func_code;
            exc_q     <= exception;
            addr_q    <= addr;
            data_q    <= data;
            len_q     <= req_len;
            byte_cnt  <= 4'd0;
            reg_idx   <= 3'd0;
            crc_phase <= 1'b0;
            crc_idx   <= 1'b0;
            state     <= (req_kind == FRM_NONE) ? ST_DONE : ST_LOAD;
          end
        end
        ST_FETCH: begin
          reg_idx <= reg_idx + 3'd1;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          // the serial CRC must finish the previous byte before the next one is fed
          if (crc_phase || crc_ready) begin
            tx_data <= next_byte;
            if (!crc_phase && data_hi) begin
              hold <= reg_rd_data;
            end
            state <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (!tx_busy) begin
            if (crc_phase) begin
              crc_idx <= 1'b1;
              state   <= crc_idx ? ST_DONE : ST_LOAD;
            end else begin
              byte_cnt <= nxt_cnt;
              if (nxt_cnt == len_q) begin
                state <= ST_CRC_WAIT;
              end else if (kind == FRM_READ && nxt_cnt[0] && nxt_cnt >= 4'd3) begin
                reg_rd_addr <= addr_q + {13'd0, reg_idx};
                state       <= ST_FETCH;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
        end
        ST_CRC_WAIT: begin
          if (crc_ready) begin
            crc_phase <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mb_crc16_serial u_crc (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .init       (crc_init),
    .byte_valid (crc_feed),
    .byte_in    (tx_data),
    .crc        (crc),
    .crc_ready  (crc_ready)
  );

endmodule

// File: tb/tb_modbus_resp_tx.sv
// Directed bench for modbus_resp_tx: expected wire bytes and register reads are queued
// at stimulus time and consumed by a monitor that watches tx_start / reg_rd_addr.
module tb_modbus_resp_tx;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        exception_done;
  logic [7:0]  exception;
  logic [7:0]  func_code;
  logic [15:0] addr;
  logic [15:0] data;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_len = 12;
  int busy_cnt;
  int req_cyc;
  int fall_cyc;
  int done_cnt = 0;
  int start_cnt = 0;
  bit lat_pending = 1'b0;
  bit sent_frame = 1'b0;
  bit prev_busy = 1'b0;
  logic [15:0] prev_rd = 16'h0000;
  logic [7:0]  cur_byte = 8'h00;
  logic [15:0] tb_crc;
  logic [15:0] mem [16];
  logic [7:0]  exp_q [$];
  logic [15:0] exp_rd_q [$];
  logic [15:0] obs_rd_q [$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc = cyc + 1;

  modbus_resp_tx #(.SLAVE_ADDR(8'h01), .MAX_REGS(5)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .exception_done (exception_done),
    .exception      (exception),
    .func_code      (func_code),
    .addr           (addr),
    .data           (data),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_data    (reg_rd_data),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done)
  );

  // UART model: busy from the cycle after tx_start for busy_len cycles
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  // register file with one cycle read latency
  always @(posedge clk_in) reg_rd_data <= mem[reg_rd_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_busy = 1'b0;
      prev_rd   = 16'h0000;
    end else begin
      if (tx_start) begin
        start_cnt++;
        chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_byte: observed=%0h expected=none", tx_data);
        end
        if (exp_q.size() != 0) chk("wire_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        if (lat_pending) begin
          chk("first_byte_latency", cyc - req_cyc, 2);
          lat_pending = 1'b0;
        end
        cur_byte = tx_data;
      end else if (tx_busy) begin
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, cur_byte});
      end
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      if (frame_done) begin
        done_cnt++;
        if (sent_frame) chk("done_gap", cyc - fall_cyc, 1);
      end
      if (reg_rd_addr !== prev_rd) obs_rd_q.push_back(reg_rd_addr);
      prev_busy = tx_busy;
      prev_rd   = reg_rd_addr;
    end
  end

  task automatic begin_frame();
    tb_crc = 16'hFFFF;
    exp_rd_q.delete();
    obs_rd_q.delete();
    sent_frame = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    tb_crc = tb_crc ^ {8'h00, b};
    for (int k = 0; k < 8; k++) tb_crc = tb_crc[0] ? ((tb_crc >> 1) ^ 16'hA001) : (tb_crc >> 1);
  endtask

  task automatic push_crc();
    logic [15:0] c;
    c = tb_crc;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic push_read(input logic [7:0] fc, input logic [15:0] a, input int n_raw);
    int n;
    logic [15:0] v;
    logic [15:0] ra;
    n = (n_raw > 5) ? 5 : n_raw;
    begin_frame();
    push_byte(8'h01);
    push_byte(fc);
    push_byte(8'(2 * n));
    for (int i = 0; i < n; i++) begin
      ra = a + 16'(i);
      v = mem[ra[3:0]];
      exp_rd_q.push_back(ra);
      push_byte(v[15:8]);
      push_byte(v[7:0]);
    end
    push_crc();
  endtask

  task automatic issue(input logic [7:0] fc, input logic [7:0] exc, input logic [15:0] a,
                       input logic [15:0] d, input bit expect_frame);
    @(negedge clk_in);
    func_code = fc;
    exception = exc;
    addr = a;
    data = d;
    exception_done = 1'b1;
    if (expect_frame) begin
      req_cyc = cyc;
      lat_pending = 1'b1;
    end
    @(negedge clk_in);
    exception_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done_cnt > start}, 32'd1);
    chk({tag, "_busy_low"}, {31'd0, frame_busy}, 32'd0);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_rd_count"}, obs_rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++)
      chk({tag, "_rd_addr"}, {16'd0, obs_rd_q[i]}, {16'd0, exp_rd_q[i]});
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1111 * 16'(i);
    mem[1] = 16'h1234;
    mem[2] = 16'hABCD;
    rst_n_in = 1'b0;
    exception_done = 1'b0;
    exception = 8'h00;
    func_code = 8'h00;
    addr = 16'h0000;
    data = 16'h0000;
    repeat (3) @(negedge clk_in);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rd_addr", {16'd0, reg_rd_addr}, 32'd0);
    chk("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // exception reply, literal wire bytes
    begin_frame();
    exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    issue(8'h03, 8'h02, 16'h0000, 16'h0001, 1'b1);
    wait_done("exc", 500);

    // write echo with stretched busy and an ignored second request
    begin_frame();
    exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    busy_len = 100;
    issue(8'h06, 8'h00, 16'h0001, 16'h0003, 1'b1);
    repeat (150) @(negedge clk_in);
    chk("busy_mid_frame", {31'd0, frame_busy}, 32'd1);
    issue(8'h03, 8'h01, 16'h0000, 16'h0001, 1'b0);
    wait_done("write", 3000);
    busy_len = 12;
    repeat (5) @(negedge clk_in);
    chk("ignored_no_frame", start_cnt, 13);

    push_read(8'h04, 16'h0001, 2);
    issue(8'h04, 8'h00, 16'h0001, 16'h0002, 1'b1);
    wait_done("read2", 800);

    push_read(8'h03, 16'h0005, 0);
    issue(8'h03, 8'h00, 16'h0005, 16'h0000, 1'b1);
    wait_done("read0", 500);

    // quantity 7 clipped to 5 registers
    push_read(8'h03, 16'h0003, 7);
    issue(8'h03, 8'h00, 16'h0003, 16'h0007, 1'b1);
    wait_done("clip", 1500);

    // unsupported function: frame_done only
    sent_frame = 1'b0;
    n = start_cnt;
    issue(8'h10, 8'h00, 16'h0000, 16'h0000, 1'b0);
    #1;
    chk("nofunc_done", {31'd0, frame_done}, 32'd1);
    chk("nofunc_busy", {31'd0, frame_busy}, 32'd0);
    repeat (5) @(negedge clk_in);
    chk("nofunc_no_start", start_cnt, n);

    // reset while the third byte is on the wire
    begin_frame();
    exp_q = '{8'h01, 8'h06, 8'h00, 8'hAA, 8'h55, 8'h55};
    n = start_cnt;
    issue(8'h06, 8'h00, 16'h00AA, 16'h5555, 1'b1);
    for (int i = 0; i < 500 && start_cnt < n + 3; i++) @(negedge clk_in);
    chk("third_byte_seen", start_cnt, n + 3);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
    chk("abort_tx_data", {24'd0, tx_data}, 32'd0);
    chk("abort_rd_addr", {16'd0, reg_rd_addr}, 32'd0);
    chk("abort_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    lat_pending = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    push_read(8'h04, 16'h0001, 2);
    issue(8'h04, 8'h00, 16'h0001, 16'h0002, 1'b1);
    wait_done("after_reset", 800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
